uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive buffer that sits directly downstream of the UART receiver.
//   Captures each byte on P_DATA when data_valid pulses, holds it in a
//   first-word-fall-through FIFO for the system side, and keeps sticky
//   overrun plus saturating parity/stop/start-glitch error counters.
// PARAMETERS
//   DEPTH   8   FIFO entries; must be a power of two, >= 2
//   ADDR_W  3   log2(DEPTH)
//   CNT_W   8   width of each error counter
// PORTS
//   CLK          in   1       single clock for all logic
//   RST          in   1       asynchronous reset, active low
//   P_DATA       in   8       received byte from the UART receiver
//   data_valid   in   1       one-cycle strobe: P_DATA holds a good frame
//   par_err      in   1       parity error flag from the receiver (level)
//   stp_err      in   1       stop error flag from the receiver (level)
//   strt_glitch  in   1       start glitch flag from the receiver (level)
//   RD_EN        in   1       pop request from the consumer
//   CLR_ERR      in   1       one-cycle clear: OVERRUN and all counters
//   RD_DATA      out  8       head-of-FIFO byte; valid while RD_VALID=1
//   RD_VALID     out  1       FIFO not empty
//   FULL         out  1       COUNT == DEPTH
//   COUNT        out  ADDR_W+1  number of stored bytes
//   OVERRUN      out  1       sticky: a byte was dropped while full
//   PAR_ERR_CNT  out  CNT_W   parity error events, saturating
//   STP_ERR_CNT  out  CNT_W   stop error events, saturating
//   GLT_ERR_CNT  out  CNT_W   start glitch events, saturating
// BEHAVIOUR
//   Reset (RST=0, async):
//     - pointers, COUNT, OVERRUN, counters and edge regs are 0
//     - RD_VALID=0, FULL=0; memory contents are not reset
//   Storage: registered RAM plus wr_ptr/rd_ptr (ADDR_W bits, natural
//     wrap at DEPTH) and an ADDR_W+1 bit COUNT register.
//   Push: on the edge where data_valid=1 and (!FULL or pop this edge):
//     mem[wr_ptr]<=P_DATA, wr_ptr++.
//   Pop: on the edge where RD_EN=1 and RD_VALID=1: rd_ptr++.
//     RD_EN while empty is ignored.
//   COUNT rules:
//     - +1 on push only; -1 on pop only; unchanged on push and pop
//     - push while full with RD_EN=1 is accepted (COUNT stays DEPTH)
//   FWFT latency: a byte pushed at edge N appears on RD_DATA with
//     RD_VALID=1 from after edge N. RD_DATA = mem[rd_ptr].
//     RD_DATA is don't-care while RD_VALID=0.
//   Empty + data_valid + RD_EN on the same edge: push only; the pop is
//     ignored.
//   Overrun: data_valid=1 while FULL=1 and RD_EN=0:
//     - byte is dropped; FIFO is unchanged
//     - OVERRUN<=1 and stays 1 until CLR_ERR or reset
//   Error counting:
//     - each flag is registered; an event is a rising edge (flag=1 and
//       last registered value=0), so a held flag counts once
//     - a flag already high at the first cycle after reset counts once
//     - counters stop at 2^CNT_W-1 (no wrap)
//     - flags never push data; data_valid is the only write strobe
//   CLR_ERR:
//     - clears OVERRUN and the three counters on that edge
//     - an event on the same edge gives a count of 1
//     - an overrun on the same edge gives OVERRUN=1
//     - FIFO contents and pointers are not affected
//   Reset asserted mid-operation empties the FIFO at once: RD_VALID=0
//     asynchronously.
// TESTING
//   1 reset: RD_VALID=0, FULL=0, COUNT=0, OVERRUN=0, all counters 0.
//   2 push 0xA5, 0x3C via data_valid pulses -> RD_DATA=0xA5,
//     RD_VALID=1 one edge later; RD_EN -> RD_DATA=0x3C; RD_EN -> empty.
//   3 push 8 bytes -> FULL=1, COUNT=8; 9th push with RD_EN=0 ->
//     OVERRUN=1, COUNT=8, head unchanged.
//   4 full, push 0x77 with RD_EN=1 -> no overrun, COUNT=8, 0x77 read
//     out last; drain order matches push order across pointer wrap.
//   5 hold par_err high 10 cycles, pulse stp_err 3 times -> PAR_ERR_CNT=1,
//     STP_ERR_CNT=3; 300 glitch pulses -> GLT_ERR_CNT=255.
//   6 CLR_ERR with stp_err rising on the same edge -> STP_ERR_CNT=1,
//     other counters 0, OVERRUN=0; RST low mid-burst -> COUNT=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer downstream of a UART receiver.
// Captures each good byte into a first-word-fall-through FIFO and
// tracks a sticky overrun flag plus saturating counters for parity,
// stop and start-glitch error events.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        P_DATA,
  input  logic              data_valid,
  input  logic              par_err,
  input  logic              stp_err,
  input  logic              strt_glitch,
  input  logic              RD_EN,
  input  logic              CLR_ERR,
  output logic [7:0]        RD_DATA,
  output logic              RD_VALID,
  output logic              FULL,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVERRUN,
  output logic [CNT_W-1:0]  PAR_ERR_CNT,
  output logic [CNT_W-1:0]  STP_ERR_CNT,
  output logic [CNT_W-1:0]  GLT_ERR_CNT
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // Storage and FIFO bookkeeping
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;

  // Previous value of each receiver error flag, for edge detection
  logic              par_flag_q, par_flag_d;
  logic              stp_flag_q, stp_flag_d;
  logic              glt_flag_q, glt_flag_d;

  // Saturating error event counters
  logic [CNT_W-1:0]  par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0]  stp_cnt_q, stp_cnt_d;
  logic [CNT_W-1:0]  glt_cnt_q, glt_cnt_d;

  // Decoded handshake terms
  logic              full;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              drop;
  logic              par_evt;
  logic              stp_evt;
  logic              glt_evt;

  // Counter update: a clear restarts from this edge's event, otherwise
  // count up and stick at the maximum value.
  function automatic logic [CNT_W-1:0] next_cnt(
    input logic [CNT_W-1:0] cnt,
    input logic             evt,
    input logic             clr
  );
    logic [CNT_W-1:0] res;
    res = cnt;
    if (clr) begin
      res = CNT_W'(evt);
    end else if (evt && (cnt != CNT_MAX)) begin
      res = cnt + CNT_W'(1);
    end
    return res;
  endfunction

  // Decode push/pop/drop; a full FIFO still accepts a byte when the
  // consumer frees a slot on the same edge, and an empty FIFO never pops.
  always_comb begin
    full      = (count_q == DEPTH_C);
    not_empty = (count_q != '0);
    pop       = RD_EN && not_empty;
    push      = data_valid && (!full || pop);
    drop      = data_valid && full && !RD_EN;
  end

  // Next-state for pointers and occupancy count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky overrun; a drop on the clearing edge wins over the clear
  always_comb begin
    overrun_d = overrun_q;
    if (CLR_ERR) begin
      overrun_d = drop;
    end else if (drop) begin
      overrun_d = 1'b1;
    end
  end

  // Rising-edge detection on the receiver error flags
  always_comb begin
    par_flag_d = par_err;
    stp_flag_d = stp_err;
    glt_flag_d = strt_glitch;
    par_evt    = par_err && !par_flag_q;
    stp_evt    = stp_err && !stp_flag_q;
    glt_evt    = strt_glitch && !glt_flag_q;
  end

  // Error counter next-state
  always_comb begin
    par_cnt_d = next_cnt(par_cnt_q, par_evt, CLR_ERR);
    stp_cnt_d = next_cnt(stp_cnt_q, stp_evt, CLR_ERR);
    glt_cnt_d = next_cnt(glt_cnt_q, glt_evt, CLR_ERR);
  end

  // Control and status registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      glt_flag_q <= 1'b0;
      par_cnt_q  <= '0;
      stp_cnt_q  <= '0;
      glt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      glt_flag_q <= glt_flag_d;
      par_cnt_q  <= par_cnt_d;
      stp_cnt_q  <= stp_cnt_d;
      glt_cnt_q  <= glt_cnt_d;
    end
  end

  // Data RAM write port; contents are deliberately left unreset
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= P_DATA;
    end
  end

  // Head of FIFO falls through combinationally from the RAM
  always_comb begin
    RD_DATA     = mem_q[rd_ptr_q];
    RD_VALID    = not_empty;
    FULL        = full;
    COUNT       = count_q;
    OVERRUN     = overrun_q;
    PAR_ERR_CNT = par_cnt_q;
    STP_ERR_CNT = stp_cnt_q;
    GLT_ERR_CNT = glt_cnt_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo with a queue-based
// reference model for the FIFO and plain counters for the error logic.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic        CLK;
  logic        RST;
  logic [7:0]  P_DATA;
  logic        data_valid;
  logic        par_err;
  logic        stp_err;
  logic        strt_glitch;
  logic        RD_EN;
  logic        CLR_ERR;
  logic [7:0]  RD_DATA;
  logic        RD_VALID;
  logic        FULL;
  logic [3:0]  COUNT;
  logic        OVERRUN;
  logic [7:0]  PAR_ERR_CNT;
  logic [7:0]  STP_ERR_CNT;
  logic [7:0]  GLT_ERR_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int m_ovr = 0;
  int m_par = 0;
  int m_stp = 0;
  int m_glt = 0;
  bit prev_p = 0;
  bit prev_s = 0;
  bit prev_g = 0;

  uart_rx_fifo #(.DEPTH(8), .ADDR_W(3), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch),
    .RD_EN(RD_EN), .CLR_ERR(CLR_ERR), .RD_DATA(RD_DATA),
    .RD_VALID(RD_VALID), .FULL(FULL), .COUNT(COUNT), .OVERRUN(OVERRUN),
    .PAR_ERR_CNT(PAR_ERR_CNT), .STP_ERR_CNT(STP_ERR_CNT),
    .GLT_ERR_CNT(GLT_ERR_CNT)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkVal(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  function automatic int satAdd(input int cnt, input bit evt);
    if (cnt + int'(evt) > 255) return 255;
    return cnt + int'(evt);
  endfunction

  // Compare all status outputs with the model after an edge
  task automatic checkOutput();
    checkVal("COUNT", int'(COUNT), exp_q.size());
    checkVal("FULL", int'(FULL), int'(exp_q.size() == DEPTH));
    checkVal("RD_VALID", int'(RD_VALID), int'(exp_q.size() != 0));
    checkVal("OVERRUN", int'(OVERRUN), m_ovr);
    checkVal("PAR_ERR_CNT", int'(PAR_ERR_CNT), m_par);
    checkVal("STP_ERR_CNT", int'(STP_ERR_CNT), m_stp);
    checkVal("GLT_ERR_CNT", int'(GLT_ERR_CNT), m_glt);
    if (exp_q.size() != 0) checkVal("RD_DATA_head", int'(RD_DATA), int'(exp_q[0]));
  endtask

  // Drive one cycle of inputs, update the model, then check after the edge
  task automatic applyStimulus(input bit dv, input logic [7:0] d, input bit rd,
                               input bit p, input bit s, input bit g, input bit clr);
    int  sz;
    bit  pop_m, acc, drop, ep, es, eg;
    data_valid  = dv;
    P_DATA      = d;
    RD_EN       = rd;
    par_err     = p;
    stp_err     = s;
    strt_glitch = g;
    CLR_ERR     = clr;
    sz    = exp_q.size();
    pop_m = rd && (sz > 0);
    acc   = dv && ((sz < DEPTH) || pop_m);
    drop  = dv && (sz == DEPTH) && !rd;
    if (acc) exp_q.push_back(d);
    ep = p && !prev_p;
    es = s && !prev_s;
    eg = g && !prev_g;
    prev_p = p;
    prev_s = s;
    prev_g = g;
    m_par = clr ? int'(ep) : satAdd(m_par, ep);
    m_stp = clr ? int'(es) : satAdd(m_stp, es);
    m_glt = clr ? int'(eg) : satAdd(m_glt, eg);
    m_ovr = clr ? int'(drop) : (m_ovr | int'(drop));
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every accepted pop must present the oldest expected byte
  initial begin
    forever begin
      @(negedge CLK);
      if (RST && RD_VALID && RD_EN) begin
        if (exp_q.size() == 0) begin
          checkVal("pop_on_empty_model", 1, 0);
        end else begin
          checkVal("pop_data", int'(RD_DATA), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    RST = 1'b0;
    P_DATA = '0; data_valid = 0; par_err = 0; stp_err = 0;
    strt_glitch = 0; RD_EN = 0; CLR_ERR = 0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput();
    RST = 1'b1;

    // Basic push then pop
    applyStimulus(1, 8'hA5, 0, 0, 0, 0, 0);
    checkVal("head_A5", int'(RD_DATA), 8'hA5);
    applyStimulus(1, 8'h3C, 0, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0, 0);
    checkVal("head_3C", int'(RD_DATA), 8'h3C);
    applyStimulus(0, 8'h00, 1, 0, 0, 0, 0);
    checkVal("empty_after_drain", int'(RD_VALID), 0);

    // Empty with simultaneous push and read: push only
    applyStimulus(1, 8'h11, 1, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0, 0);

    // Fill, then overrun
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'($urandom), 0, 0, 0, 0, 0);
    checkVal("full_count", int'(COUNT), 8);
    applyStimulus(1, 8'hEE, 0, 0, 0, 0, 0);
    checkVal("overrun_set", int'(OVERRUN), 1);

    // Full with simultaneous pop: accepted, then drain across wrap
    applyStimulus(1, 8'h77, 1, 0, 0, 0, 0);
    checkVal("full_pushpop_count", int'(COUNT), 8);
    while (exp_q.size() > 1) applyStimulus(0, 8'h00, 1, 0, 0, 0, 0);
    checkVal("last_is_77", int'(RD_DATA), 8'h77);
    applyStimulus(0, 8'h00, 1, 0, 0, 0, 0);

    // Held parity flag, pulsed stop flag, saturating glitch counter
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 1, 0, 0);
      idle();
    end
    checkVal("par_held_once", int'(PAR_ERR_CNT), 1);
    checkVal("stp_three", int'(STP_ERR_CNT), 3);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 0, 1, 0);
      idle();
    end
    checkVal("glt_saturated", int'(GLT_ERR_CNT), 255);

    // Clear coinciding with a stop-error rising edge
    applyStimulus(0, 8'h00, 0, 1, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 1, 0, 1);
    checkVal("clr_stp_one", int'(STP_ERR_CNT), 1);
    checkVal("clr_par_zero", int'(PAR_ERR_CNT), 0);
    checkVal("clr_glt_zero", int'(GLT_ERR_CNT), 0);
    checkVal("clr_ovr_zero", int'(OVERRUN), 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(bit'($urandom_range(0, 99) < 55), 8'($urandom),
                    bit'($urandom_range(0, 99) < 45),
                    bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0),
                    bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 29) == 0));
    end

    // Reset mid-burst
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'($urandom), 0, 0, 0, 0, 0);
    data_valid = 0; RD_EN = 0; CLR_ERR = 0;
    par_err = 0; stp_err = 0; strt_glitch = 0;
    #3;
    RST = 1'b0;
    #1;
    checkVal("async_rst_count", int'(COUNT), 0);
    checkVal("async_rst_valid", int'(RD_VALID), 0);
    exp_q.delete();
    m_ovr = 0; m_par = 0; m_stp = 0; m_glt = 0;
    prev_p = 0; prev_s = 0; prev_g = 0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    checkOutput();
    applyStimulus(1, 8'h5A, 0, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
